// File: rtl/hmac_seq_pkg.sv
// hmac_seq_pkg: FSM states and block/padding geometry shared by the
// HMAC message sequencer, its block buffer and its bus interface.
package hmac_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      PAD,
      ISSUE,
      WAIT
   } state_t;

   localparam int WORDS_PER_BLOCK = 32;
   localparam logic [7:0] PAD_BYTE = 8'h80;
   localparam int LEN_FIELD_LSB_LIMIT = 111;
   localparam int IPAD_BITS = 1024;

endpackage

// File: rtl/hmac_seq_if.sv
// hmac_seq_if: message word stream plus hmac_core command/tag side.
// master = stream source and core; slave = the sequencer.
interface hmac_seq_if;

   logic          msg_valid;
   logic          msg_ready;
   logic [31:0]   msg_data;
   logic          msg_last;
   logic [2:0]    msg_bytes;
   logic          core_init;
   logic          core_next;
   logic          core_ready;
   logic          core_tag_valid;
   logic [383:0]  core_tag;
   logic [1023:0] core_block;

   modport master (
      output msg_valid, msg_data, msg_last, msg_bytes,
      output core_ready, core_tag_valid, core_tag,
      input  msg_ready, core_init, core_next, core_block
   );

   modport slave (
      input  msg_valid, msg_data, msg_last, msg_bytes,
      input  core_ready, core_tag_valid, core_tag,
      output msg_ready, core_init, core_next, core_block
   );

endinterface

// File: rtl/hmac_block_buf.sv
// hmac_block_buf: 1024-bit block buffer. Ports: clr, byte-masked word
// write (wr_*), 0x80 marker at byte pad_pos, 128-bit length field, q.
module hmac_block_buf
   import hmac_seq_pkg::*;
(
   input  logic          clk,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [4:0]    wr_idx,
   input  logic [31:0]   wr_data,
   input  logic [2:0]    wr_bytes,
   input  logic          pad_en,
   input  logic [6:0]    pad_pos,
   input  logic          len_en,
   input  logic [127:0]  len,
   output logic [1023:0] q
);

   // Byte n of the block lives at bits 1023-8n down.
   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else begin
         if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
               q[1023 - 8*(4*int'(wr_idx) + k) -: 8] <=
                  (k < int'(wr_bytes)) ? wr_data[31 - 8*k -: 8] : 8'h00;
            end
         end
         if (pad_en) begin
            q[1023 - 8*int'(pad_pos) -: 8] <= PAD_BYTE;
         end
         if (len_en) begin
            q[127:0] <= len;
         end
      end
   end

endmodule

// File: rtl/hmac_msg_sequencer.sv
// hmac_msg_sequencer: packs a 32-bit word stream into padded SHA-384
// blocks for hmac_core. Ports: clk/reset/zeroize/start, bus (slave),
// tag/tag_valid captured result, busy, sticky error.
module hmac_msg_sequencer
   import hmac_seq_pkg::*;
#(
   parameter int LEN_W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         zeroize,
   input  logic         start,
   hmac_seq_if.slave    bus,
   output logic [383:0] tag,
   output logic         tag_valid,
   output logic         busy,
   output logic         error
);

   localparam logic [4:0] LAST_W = 5'(WORDS_PER_BLOCK - 1);

   state_t           state, state_nx;
   logic [4:0]       widx;
   logic [LEN_W-1:0] count;
   logic [2:0]       lastb;
   logic             first, pend80, extra, fin;
   logic             clr_all, xfer, bad, wr_en;
   logic [LEN_W:0]   count_sum;
   logic [7:0]       ppos;
   logic             fsm_clr, buf_clr;
   logic             pad_ins, len_ins, pad_fin, pad_pend, pad_extra;
   logic             pad_we, len_we;
   logic [6:0]       pad_pos;
   logic [127:0]     len_val;

   assign clr_all   = reset | zeroize;
   assign xfer      = (state == FILL) & bus.msg_valid;
   assign count_sum = {1'b0, count} + (LEN_W+1)'(bus.msg_bytes);
   assign bad       = xfer & ((~bus.msg_last & (bus.msg_bytes != 3'd4))
                      | (bus.msg_bytes > 3'd4) | count_sum[LEN_W]);
   assign wr_en     = xfer & ~bad;
   // Marker offset just past the last data byte; 128 means block full.
   assign ppos      = {1'b0, widx, 2'b00} + {5'b0, lastb};
   // Length covers the ipad block already hashed by the core.
   assign len_val   = 128'(IPAD_BITS) + 128'({count, 3'b000});
   assign busy      = (state != IDLE);
   assign buf_clr   = clr_all | fsm_clr;
   assign pad_we    = (state == PAD) & pad_ins;
   assign len_we    = (state == PAD) & len_ins;

   always_comb begin
      pad_ins   = 1'b0;
      len_ins   = 1'b0;
      pad_fin   = 1'b0;
      pad_pend  = 1'b0;
      pad_extra = 1'b0;
      pad_pos   = '0;
      if (pend80) begin
         pad_ins = 1'b1;
         len_ins = 1'b1;
         pad_fin = 1'b1;
      end else if (extra) begin
         len_ins = 1'b1;
         pad_fin = 1'b1;
      end else if (ppos == 8'd128) begin
         pad_pend = 1'b1;
      end else begin
         pad_ins = 1'b1;
         pad_pos = ppos[6:0];
         if (ppos <= 8'(LEN_FIELD_LSB_LIMIT)) begin
            len_ins = 1'b1;
            pad_fin = 1'b1;
         end else begin
            pad_extra = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr_all) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      fsm_clr       = 1'b0;
      bus.msg_ready = 1'b0;
      bus.core_init = 1'b0;
      bus.core_next = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = FILL;
               fsm_clr  = 1'b1;
            end
         end
         FILL: begin
            bus.msg_ready = 1'b1;
            if (bad) begin
               state_nx = IDLE;
            end else if (xfer) begin
               if (bus.msg_last)        state_nx = PAD;
               else if (widx == LAST_W) state_nx = ISSUE;
            end
         end
         PAD: state_nx = ISSUE;
         ISSUE: begin
            if (bus.core_ready) begin
               bus.core_init = first;
               bus.core_next = ~first;
               state_nx      = WAIT;
            end
         end
         WAIT: begin
            if (bus.core_tag_valid) begin
               if (fin) begin
                  state_nx = IDLE;
               end else begin
                  fsm_clr  = 1'b1;
                  state_nx = (extra | pend80) ? PAD : FILL;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr_all) begin
         widx      <= '0;
         count     <= '0;
         lastb     <= '0;
         first     <= 1'b0;
         pend80    <= 1'b0;
         extra     <= 1'b0;
         fin       <= 1'b0;
         tag       <= '0;
         tag_valid <= 1'b0;
         error     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  widx      <= '0;
                  count     <= '0;
                  first     <= 1'b1;
                  pend80    <= 1'b0;
                  extra     <= 1'b0;
                  fin       <= 1'b0;
                  tag_valid <= 1'b0;
                  error     <= 1'b0;
               end
            end
            FILL: begin
               if (bad) begin
                  error <= 1'b1;
               end else if (xfer) begin
                  count <= count_sum[LEN_W-1:0];
                  if (bus.msg_last)        lastb <= bus.msg_bytes;
                  else if (widx == LAST_W) fin   <= 1'b0;
                  else                     widx  <= widx + 5'd1;
               end
            end
            PAD: begin
               pend80 <= pad_pend;
               extra  <= pad_extra;
               fin    <= pad_fin;
            end
            ISSUE: begin
               if (bus.core_ready) first <= 1'b0;
            end
            WAIT: begin
               if (bus.core_tag_valid) begin
                  if (fin) begin
                     tag       <= bus.core_tag;
                     tag_valid <= 1'b1;
                  end else begin
                     widx <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   hmac_block_buf u_buf (
      .clk     (clk),
      .clr     (buf_clr),
      .wr_en   (wr_en),
      .wr_idx  (widx),
      .wr_data (bus.msg_data),
      .wr_bytes(bus.msg_bytes),
      .pad_en  (pad_we),
      .pad_pos (pad_pos),
      .len_en  (len_we),
      .len     (len_val),
      .q       (bus.core_block)
   );

endmodule
